// File: rtl/l2_reqs_sched_pkg.sv
// Shared definitions for the L2 request-buffer scheduler: buffer op codes,
// FSM state enum, requester ids and retry-counter sizing.
package l2_reqs_sched_pkg;

    // Op codes presented to the request buffer.
    localparam logic [2:0] L2_REQS_IDLE       = 3'd0;
    localparam logic [2:0] L2_REQS_PEEK_REQ   = 3'd1;
    localparam logic [2:0] L2_REQS_PEEK_FWD   = 3'd2;
    localparam logic [2:0] L2_REQS_PEEK_FLUSH = 3'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEEK   = 2'd1,
        DECIDE = 2'd2
    } sched_state_e;

    // Requester ids double as bit positions in the one-hot grant vector.
    typedef enum logic [1:0] {
        REQ_CPU   = 2'd0,
        REQ_FLUSH = 2'd1,
        REQ_FWD   = 2'd2
    } req_id_e;

    localparam int N_REQ_IDS = 3;

    // Starvation guard for the cpu requester.
    localparam int                 RETRY_W   = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    // Peek op code issued on behalf of a granted requester.
    function automatic logic [2:0] peek_op(input req_id_e id);
        case (id)
            REQ_FWD:   return L2_REQS_PEEK_FWD;
            REQ_FLUSH: return L2_REQS_PEEK_FLUSH;
            default:   return L2_REQS_PEEK_REQ;
        endcase
    endfunction

endpackage

// File: rtl/l2_reqs_sched_arb.sv
// Requester arbiter: fwd always wins; cpu vs flush is decided by the
// round-robin pointer (0 favours cpu) unless the cpu retry counter is
// saturated, in which case cpu wins.
module l2_reqs_sched_arb
    import l2_reqs_sched_pkg::*;
(
    input  logic                 fwd_valid_i,
    input  logic                 cpu_valid_i,
    input  logic                 flush_valid_i,
    input  logic                 rr_ptr_i,
    input  logic                 retry_sat_i,
    output logic [N_REQ_IDS-1:0] grant_o
);

    // One-hot grant selection.
    always_comb begin
        grant_o = '0;
        if (fwd_valid_i) begin
            grant_o[REQ_FWD] = 1'b1;
        end else if (cpu_valid_i && flush_valid_i) begin
            if (retry_sat_i || !rr_ptr_i) begin
                grant_o[REQ_CPU] = 1'b1;
            end else begin
                grant_o[REQ_FLUSH] = 1'b1;
            end
        end else if (cpu_valid_i) begin
            grant_o[REQ_CPU] = 1'b1;
        end else if (flush_valid_i) begin
            grant_o[REQ_FLUSH] = 1'b1;
        end
    end

endmodule

// File: rtl/l2_reqs_sched.sv
// L2 request-buffer scheduler. IDLE latches a grant, PEEK issues the peek
// op code for one cycle, DECIDE acknowledges (or stalls) the requester.
// Handshake: a requester holds *_valid until it sees its one-cycle *_ready
// pulse in DECIDE; the transfer happens on the rising edge ending that cycle.
// Dropping valid before then abandons the attempt with no ready and no fill.
// Build option: define L2_REQS_SCHED_RR_EN for round-robin cpu/flush
// arbitration; otherwise cpu has fixed priority over flush.
module l2_reqs_sched
    import l2_reqs_sched_pkg::*;
#(
    parameter int N_REQS    = 4,
    parameter int REQS_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req_valid,
    input  logic                 flush_req_valid,
    input  logic                 fwd_req_valid,
    output logic                 cpu_req_ready,
    output logic                 flush_req_ready,
    output logic                 fwd_req_ready,
    input  logic [N_REQS-1:0]    entry_free,
    input  logic                 set_conflict,
    output logic [2:0]           reqs_op_code,
    output logic                 fill_reqs,
    output logic                 fill_reqs_flush,
    output logic [REQS_BITS:0]   free_cnt,
    output logic                 reqs_full,
    output logic                 busy,
    output sched_state_e         dbg_state_o,
    output logic [RETRY_W-1:0]   dbg_retry_o
);

    sched_state_e           state_q;
    req_id_e                grant_q;
    req_id_e                grant_id;
    logic [2:0]             op_q;
    logic                   drop_q;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [REQS_BITS:0]     free_cnt_q, free_cnt_d;
    logic [N_REQ_IDS-1:0]   grant_oh;
    logic                   rr_ptr;
    logic                   any_valid, granted_valid, live;
    logic                   cpu_acc, cpu_stall, flush_acc, fwd_acc;

    assign any_valid = cpu_req_valid | flush_req_valid | fwd_req_valid;

    l2_reqs_sched_arb u_arb (
        .fwd_valid_i   (fwd_req_valid),
        .cpu_valid_i   (cpu_req_valid),
        .flush_valid_i (flush_req_valid),
        .rr_ptr_i      (rr_ptr),
        .retry_sat_i   (retry_q == RETRY_MAX),
        .grant_o       (grant_oh)
    );

    // Encode the one-hot grant into a requester id.
    always_comb begin
        grant_id = REQ_CPU;
        if (grant_oh[REQ_FWD]) begin
            grant_id = REQ_FWD;
        end else if (grant_oh[REQ_FLUSH]) begin
            grant_id = REQ_FLUSH;
        end
    end

    // Current valid of the requester that owns the sequence.
    always_comb begin
        case (grant_q)
            REQ_FWD:   granted_valid = fwd_req_valid;
            REQ_FLUSH: granted_valid = flush_req_valid;
            default:   granted_valid = cpu_req_valid;
        endcase
    end

    // DECIDE outcome; set_conflict is only valid here, one cycle after the peek.
    assign live      = (state_q == DECIDE) && granted_valid && !drop_q;
    assign fwd_acc   = live && (grant_q == REQ_FWD);
    assign cpu_acc   = live && (grant_q == REQ_CPU) && !reqs_full && !set_conflict;
    assign cpu_stall = live && (grant_q == REQ_CPU) && (reqs_full || set_conflict);
    assign flush_acc = live && (grant_q == REQ_FLUSH) && !reqs_full;

    // Scheduler FSM: grant latch, peek op code and drop tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= REQ_CPU;
            op_q    <= L2_REQS_IDLE;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        state_q <= PEEK;
                        grant_q <= grant_id;
                        op_q    <= peek_op(grant_id);
                        drop_q  <= 1'b0;
                    end
                end
                PEEK: begin
                    state_q <= DECIDE;
                    op_q    <= L2_REQS_IDLE;
                    if (!granted_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                DECIDE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    op_q    <= L2_REQS_IDLE;
                end
            endcase
        end
    end

    // Next retry count: clear on cpu accept, saturating increment on cpu stall.
    always_comb begin
        retry_d = retry_q;
        if (cpu_acc) begin
            retry_d = '0;
        end else if (cpu_stall && (retry_q != RETRY_MAX)) begin
            retry_d = retry_q + 1'b1;
        end
    end

    // Population count of free entries.
    always_comb begin
        free_cnt_d = '0;
        for (int i = 0; i < N_REQS; i++) begin
            free_cnt_d = free_cnt_d + {{REQS_BITS{1'b0}}, entry_free[i]};
        end
    end

    // Status and retry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q    <= '0;
            free_cnt_q <= '0;
        end else begin
            retry_q    <= retry_d;
            free_cnt_q <= free_cnt_d;
        end
    end

`ifdef L2_REQS_SCHED_RR_EN
    logic rr_ptr_q;

    // Round-robin pointer: 0 favours cpu, flips on every cpu or flush accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else if (cpu_acc || flush_acc) begin
            rr_ptr_q <= ~rr_ptr_q;
        end
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = 1'b0;
`endif

    assign cpu_req_ready   = cpu_acc;
    assign fill_reqs       = cpu_acc;
    assign flush_req_ready = flush_acc;
    assign fill_reqs_flush = flush_acc;
    assign fwd_req_ready   = fwd_acc;
    assign reqs_op_code    = op_q;
    assign free_cnt        = free_cnt_q;
    assign reqs_full       = (free_cnt_q == '0);
    assign busy            = (state_q != IDLE);
    assign dbg_state_o     = state_q;
    assign dbg_retry_o     = retry_q;

endmodule

// File: doc/l2_reqs_sched.md
L2_REQS_SCHED -- requirements
Module: l2_reqs_sched

Interface
REQ-001 SHALL have parameter N_REQS, default 4, number of request-buffer entries.
REQ-002 SHALL have parameter REQS_BITS, default 2, entry index width, equal to clog2(N_REQS).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports cpu_req_valid / flush_req_valid / fwd_req_valid, input, 1 each, requester wants buffer access.
REQ-006 SHALL have ports cpu_req_ready / flush_req_ready / fwd_req_ready, output, 1 each, one-cycle accept pulse.
REQ-007 SHALL have port entry_free, input, N_REQS, per-entry "state == INVALID" from the buffer.
REQ-008 SHALL have port set_conflict, input, 1, registered set-conflict result of the last PEEK_REQ.
REQ-009 SHALL have port reqs_op_code, output, 3, buffer op code (L2_REQS_* encodings).
REQ-010 SHALL have ports fill_reqs / fill_reqs_flush, output, 1 each, buffer allocate strobes.
REQ-011 SHALL have ports free_cnt (REQS_BITS+1), reqs_full (1), busy (1), output, status.

Function
REQ-012 SHALL implement FSM states IDLE, PEEK, DECIDE; reset state IDLE.
REQ-013 IDLE: if any valid is high, SHALL latch a grant (fwd > cpu/flush) and go to PEEK; otherwise stay.
REQ-014 PEEK SHALL drive reqs_op_code = PEEK_FWD, PEEK_REQ or PEEK_FLUSH for the granted requester for exactly one cycle, then go to DECIDE.
REQ-015 reqs_op_code SHALL equal L2_REQS_IDLE in every cycle outside PEEK.
REQ-016 DECIDE, fwd grant: SHALL pulse fwd_req_ready, no fill strobe, return to IDLE.
REQ-017 DECIDE, cpu grant: if reqs_full = 0 and set_conflict = 0, SHALL pulse cpu_req_ready and fill_reqs together; else neither, requester retries.
REQ-018 DECIDE, flush grant: if reqs_full = 0, SHALL pulse flush_req_ready and fill_reqs_flush together; set_conflict ignored.
REQ-019 DECIDE SHALL always return to IDLE; minimum accept latency 2 cycles after valid seen in IDLE.
REQ-020 At most one ready and at most one fill strobe SHALL be high per cycle; fill_reqs and fill_reqs_flush are never both high.
REQ-021 A requester dropping valid during PEEK/DECIDE SHALL not be acknowledged; sequence completes with no ready, no fill.
REQ-022 free_cnt SHALL be the registered popcount of entry_free; reqs_full SHALL be high iff free_cnt == 0 (combinational from free_cnt).
REQ-023 busy SHALL be high in PEEK and DECIDE.
REQ-024 A stalled cpu request (full or conflict) SHALL increment a 4-bit saturating retry counter; at 15 the cpu SHALL win the next cpu/flush arbitration; counter clears on cpu accept.

Reset
REQ-025 On rst: state IDLE, all ready/fill outputs 0, reqs_op_code = L2_REQS_IDLE, free_cnt 0, busy 0, retry counter 0, round-robin pointer favours cpu.
REQ-026 rst asserted mid-sequence SHALL abort immediately; no ready or fill strobe after rst deassertion until a new IDLE grant.

Configuration
REQ-027 Macro L2_REQS_SCHED_RR_EN defined: cpu vs flush SHALL be round-robin, pointer toggling after each accept of either.
REQ-028 Macro undefined: cpu SHALL have fixed priority over flush; fwd highest in both builds; REQ-024 override applies in both.

Structure
REQ-029 FSM state enum, requester-id encoding and retry-counter width SHALL live in the shared package beside the L2_REQS_* op codes.
REQ-030 Arbitration SHALL be one sub-module, l2_reqs_sched_arb (valids, pointer, retry-sat in; one-hot grant out).

Verification
REQ-031 cpu_req_valid=1, entry_free=4'b0001, set_conflict=0 -> op PEEK_REQ at cycle 1, cpu_req_ready and fill_reqs at cycle 2.
REQ-032 fwd and cpu valid same cycle -> PEEK_FWD first, fwd_req_ready at cycle 2, cpu PEEK_REQ at cycle 4.
REQ-033 entry_free=4'b0000, flush valid -> free_cnt 0, reqs_full 1, no flush_req_ready, no fill_reqs_flush after 10 cycles.
REQ-034 cpu valid, set_conflict=1 held 16 attempts, flush also valid (RR build) -> retry counter saturates at 15, cpu granted next arbitration once conflict clears.
REQ-035 RR build, cpu and flush both continuously valid, no stall -> accepts alternate cpu, flush, cpu, flush; non-RR build -> cpu only.
REQ-036 rst asserted during DECIDE -> no ready/fill that cycle or after, reqs_op_code = L2_REQS_IDLE, state IDLE.
